// File: rtl/mxu_psum_drain.sv
// Bottom-edge partial-sum collector for one MXU row: de-skews staggered column results into one
// aligned vector behind a valid/ready output register. Define MXU_DRAIN_RELU_EN to zero negative columns on transfer.
module mxu_psum_drain #(
    parameter int bit_width = 4,
    parameter int n_cols    = 4,
    parameter int first_lat = 3,
    parameter int skew      = 2
) (
    input  logic                          clk,
    input  logic                          sclr,
    input  logic                          ce,
    input  logic                          start,
    input  logic [n_cols*bit_width-1:0]   psum_in,
    output logic [n_cols*bit_width-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          overflow,
    output logic                          start_err
);

    localparam int VW     = n_cols * bit_width;
    localparam int T_LAST = first_lat + (n_cols - 1) * skew;
    localparam int CW     = $clog2(T_LAST + 2);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [VW-1:0]   stage_q, stage_d;
    logic [VW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            overflow_q, overflow_d;
    logic            start_err_q, start_err_d;
    logic            capturing_s;
    logic            last_hit_s;
    logic            xfer_s;
    logic            load_ok_s;
    logic            start_ok_s;
    logic            start_bad_s;

    // Clamp negative columns to zero when the ReLU build option is enabled.
    function automatic logic [VW-1:0] relu_f(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = v;
`ifdef MXU_DRAIN_RELU_EN
        for (int j = 0; j < n_cols; j++) begin
            if (v[j*bit_width + bit_width - 1]) begin
                r[j*bit_width +: bit_width] = {bit_width{1'b0}};
            end else begin
                r[j*bit_width +: bit_width] = v[j*bit_width +: bit_width];
            end
        end
`endif
        return r;
    endfunction

    assign capturing_s = (state_q == ST_CAPTURE);
    assign last_hit_s  = (cnt_q == CW'(T_LAST));
    assign xfer_s      = capturing_s && ce && last_hit_s;
    assign load_ok_s   = !out_valid_q || out_ready;
    assign start_ok_s  = (state_q == ST_IDLE) && start && ce;
    assign start_bad_s = start && (!ce || capturing_s);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (xfer_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        busy = 1'b0;
        case (state_q)
            ST_IDLE:    busy = 1'b0;
            ST_CAPTURE: busy = 1'b1;
            default:    busy = 1'b0;
        endcase
    end

    // cnt holds the cycle index relative to the start cycle (start cycle is 0), frozen while ce is low.
    always_comb begin
        cnt_d   = cnt_q;
        stage_d = stage_q;
        if (start_ok_s) begin
            cnt_d = CW'(1);
        end else if (capturing_s && ce) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        for (int j = 0; j < n_cols; j++) begin
            if (capturing_s && ce && (cnt_q == CW'(first_lat + j * skew))) begin
                stage_d[j*bit_width +: bit_width] = psum_in[j*bit_width +: bit_width];
            end else begin
                stage_d[j*bit_width +: bit_width] = stage_q[j*bit_width +: bit_width];
            end
        end
    end

    // Output register, handshake and sticky flags; stage_d already carries the last column from psum_in.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        start_err_d = start_err_q || start_bad_s;
        if (xfer_s && load_ok_s) begin
            out_data_d  = relu_f(stage_d);
            out_valid_d = 1'b1;
        end else if (xfer_s) begin
            overflow_d  = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (sclr) begin
            cnt_q       <= {CW{1'b0}};
            stage_q     <= {VW{1'b0}};
            out_data_q  <= {VW{1'b0}};
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            start_err_q <= start_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign start_err = start_err_q;

endmodule

// File: tb/tb_mxu_psum_drain.sv
// Scoreboard bench for mxu_psum_drain at default parameters; expected vectors are queued at start time.
module tb_mxu_psum_drain;

    logic        clk;
    logic        sclr;
    logic        ce;
    logic        start;
    logic [15:0] psum_in;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        overflow;
    logic        start_err;

    int          n_chk;
    int          n_pass;
    logic [15:0] exp_q[$];

    mxu_psum_drain #(
        .bit_width(4),
        .n_cols   (4),
        .first_lat(3),
        .skew     (2)
    ) dut (
        .clk      (clk),
        .sclr     (sclr),
        .ce       (ce),
        .start    (start),
        .psum_in  (psum_in),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .overflow (overflow),
        .start_err(start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then wait for the falling edge to sample.
    task automatic cyc(input logic s, input logic c, input logic st, input logic rdy, input logic [15:0] p);
        @(posedge clk);
        #1;
        sclr      = s;
        ce        = c;
        start     = st;
        out_ready = rdy;
        psum_in   = p;
        @(negedge clk);
    endtask

    function automatic logic [15:0] mk_psum(input int c, input int s0, input int s1, input int s2,
                                            input int s3, input logic [15:0] v);
        logic [15:0] r;
        r = 16'hFFFF;
        if (c == s0) r[3:0]   = v[3:0];
        if (c == s1) r[7:4]   = v[7:4];
        if (c == s2) r[11:8]  = v[11:8];
        if (c == s3) r[15:12] = v[15:12];
        return r;
    endfunction

    // Monitor: every completed handshake consumes one expected vector.
    always @(negedge clk) begin
        if (!sclr && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {16'h0, out_data}, 32'hDEAD_BEEF);
            end else begin
                chk("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    endtask

    initial begin
        logic [15:0] exp_relu;
        n_chk     = 0;
        n_pass    = 0;
        sclr      = 1'b1;
        ce        = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        psum_in   = 16'hFFFF;
        do_reset();
        chk("rst_out_data", {16'h0, out_data}, 32'h0);
        chk("rst_flags", {28'h0, out_valid, busy, overflow, start_err}, 32'h0);

        // Basic drain.
        exp_q.push_back(16'h4321);
        for (int c = 0; c <= 12; c++) begin
            cyc(1'b0, 1'b1, (c == 0), 1'b1, mk_psum(c, 3, 5, 7, 9, 16'h4321));
            chk("basic_busy", {31'h0, busy}, {31'h0, (c >= 1 && c <= 9)});
            chk("basic_valid", {31'h0, out_valid}, {31'h0, (c == 10)});
        end

        // ce stall in cycles 4-5.
        do_reset();
        exp_q.push_back(16'h8765);
        for (int c = 0; c <= 14; c++) begin
            cyc(1'b0, !(c == 4 || c == 5), (c == 0), 1'b1, mk_psum(c, 3, 7, 9, 11, 16'h8765));
            chk("stall_valid", {31'h0, out_valid}, {31'h0, (c == 12)});
        end

        // Back-pressure and overflow.
        do_reset();
        exp_q.push_back(16'h4321);
        for (int c = 0; c <= 24; c++) begin
            if (c < 10) begin
                cyc(1'b0, 1'b1, (c == 0), 1'b0, mk_psum(c, 3, 5, 7, 9, 16'h4321));
            end else begin
                cyc(1'b0, 1'b1, (c == 10), (c == 23), mk_psum(c, 13, 15, 17, 19, 16'h8765));
            end
            chk("bp_overflow", {31'h0, overflow}, {31'h0, (c >= 20)});
            chk("bp_valid", {31'h0, out_valid}, {31'h0, (c >= 10 && c <= 23)});
            if (c == 21) chk("bp_held_data", {16'h0, out_data}, 32'h4321);
            if (c >= 11 && c <= 19) chk("bp_busy2", {31'h0, busy}, 32'h1);
        end

        // Simultaneous drain and load in the transfer cycle.
        do_reset();
        exp_q.push_back(16'h4321);
        exp_q.push_back(16'hCBA9);
        for (int c = 0; c <= 24; c++) begin
            if (c < 10) begin
                cyc(1'b0, 1'b1, (c == 0), 1'b0, mk_psum(c, 3, 5, 7, 9, 16'h4321));
            end else begin
                cyc(1'b0, 1'b1, (c == 10), (c == 19 || c == 23), mk_psum(c, 13, 15, 17, 19, 16'hCBA9));
            end
            chk("sim_valid", {31'h0, out_valid}, {31'h0, (c >= 10 && c <= 23)});
            if (c == 20) chk("sim_new_data", {16'h0, out_data}, 32'hCBA9);
        end
        chk("sim_no_overflow", {31'h0, overflow}, 32'h0);

        // Start while busy, then sclr aborts.
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            cyc((c == 6), 1'b1, (c == 0 || c == 5), 1'b1, mk_psum(c, 3, 5, 7, 9, 16'h1234));
            if (c <= 5) chk("se_err_low", {31'h0, start_err}, 32'h0);
            if (c == 6) chk("se_err_set", {31'h0, start_err}, 32'h1);
            if (c == 7) begin
                chk("se_rst_data", {16'h0, out_data}, 32'h0);
                chk("se_rst_flags", {28'h0, out_valid, busy, overflow, start_err}, 32'h0);
            end
            if (c >= 7) chk("se_no_valid", {31'h0, out_valid}, 32'h0);
        end

        // ReLU columns 0xF, 0x7, 0x8, 0x1.
`ifdef MXU_DRAIN_RELU_EN
        exp_relu = 16'h1070;
`else
        exp_relu = 16'h187F;
`endif
        do_reset();
        exp_q.push_back(exp_relu);
        for (int c = 0; c <= 12; c++) begin
            cyc(1'b0, 1'b1, (c == 0), 1'b1, mk_psum(c, 3, 5, 7, 9, 16'h187F));
            chk("relu_valid", {31'h0, out_valid}, {31'h0, (c == 10)});
        end

        cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF);
        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
